// File: rtl/aes_key_expand_ctrl.sv
// ---------------------------------------------------------------------------------------------
// aes_key_expand_ctrl
//   Sequential AES-128 key-expansion controller. A cipher key is taken through a valid/ready
//   handshake, expanded one round per clock, and the 11 round keys are kept in a register file.
//   The cipher round datapath reads them through a registered read port. It may read round key
//   n as soon as rk_vld_o[n] is set.
//
//   The AES-128 key-schedule round is implemented inline. It covers RotWord, SubWord, the rcon
//   xor and the word xor chain, plus the rcon xtime update.
//
// Ports
//   clk          in   1       clock
//   nreset       in   1       synchronous, active-low reset
//   key_valid_i  in   1       cipher key offered
//   key_i        in   KW      cipher key
//   key_ready_o  out  1       controller can accept a key (not expanding)
//   busy_o       out  1       expansion in progress
//   rk_vld_o     out  NR+1    bit n set: round key n stored and valid
//   done_o       out  1       one-cycle pulse after round key NR is written
//   rd_en_i      in   1       read request
//   rd_idx_i     in   4       round-key index to read
//   rd_key_o     out  KW      read data, one-cycle latency
//   rd_err_o     out  1       read of an invalid, unwritten or concurrently written index
//
// Optional feature (macro AES_KEY_STREAM_EN)
//   rk_strm_valid_o  out 1    pulses on every round-key write, including rk[0] at accept
//   rk_strm_idx_o    out 4    index of the written round key
//   rk_strm_key_o    out KW   written round key
// ---------------------------------------------------------------------------------------------
module aes_key_expand_ctrl #(
  parameter int unsigned NR        = 10,
  parameter int unsigned KW        = 128,
  parameter logic [7:0]  RCON_INIT = 8'h01
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          key_valid_i,
  input  logic [KW-1:0] key_i,
  output logic          key_ready_o,
  output logic          busy_o,
  output logic [NR:0]   rk_vld_o,
  output logic          done_o,
  input  logic          rd_en_i,
  input  logic [3:0]    rd_idx_i,
  output logic [KW-1:0] rd_key_o,
`ifdef AES_KEY_STREAM_EN
  output logic          rk_strm_valid_o,
  output logic [3:0]    rk_strm_idx_o,
  output logic [KW-1:0] rk_strm_key_o,
`endif
  output logic          rd_err_o
);

  localparam logic [3:0] LastRound = 4'(NR);

  // Forward S-box, byte 0 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [KW-1:0]   r_rk [NR+1];
  logic [KW-1:0]   r_work;
  logic [7:0]      r_rcon;
  logic [3:0]      r_round;
  logic [NR:0]     r_rk_vld;
  logic            r_done;
  logic [KW-1:0]   r_rd_key;
  logic            r_rd_err;

  logic            w_ready;
  logic            w_busy;
  logic            w_accept;
  logic            w_wr_en;
  logic [3:0]      w_wr_idx;
  logic [KW-1:0]   w_wr_key;
  logic [31:0]     w_w0, w_w1, w_w2, w_w3, w_rot, w_temp;
  logic [31:0]     w_n0, w_n1, w_n2, w_n3;
  logic [KW-1:0]   w_key_next;
  logic [7:0]      w_rcon_next;
  logic            w_rd_in_range;
  logic            w_rd_hit;
  logic            w_rd_collide;

  // ---------------- key-schedule round ----------------
  always_comb begin
    w_w0        = r_work[127:96];
    w_w1        = r_work[95:64];
    w_w2        = r_work[63:32];
    w_w3        = r_work[31:0];
    w_rot       = {w_w3[23:0], w_w3[31:24]};
    w_temp      = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                  ^ {r_rcon, 24'h000000};
    w_n0        = w_w0 ^ w_temp;
    w_n1        = w_w1 ^ w_n0;
    w_n2        = w_w2 ^ w_n1;
    w_n3        = w_w3 ^ w_n2;
    w_key_next  = {w_n0, w_n1, w_n2, w_n3};
    w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!nreset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: if (w_accept) w_state_next = StExpand;
      StExpand:       if (r_round == LastRound) w_state_next = StDone;
      default:        w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_ready     = (r_state != StExpand);
    w_busy      = (r_state == StExpand);
    w_accept    = key_valid_i & w_ready;
    key_ready_o = w_ready;
    busy_o      = w_busy;
    rk_vld_o    = r_rk_vld;
    done_o      = r_done;
    rd_key_o    = r_rd_key;
    rd_err_o    = r_rd_err;
  end

  // ---------------- write path ----------------
  // Gated by nreset so a reset cycle never disturbs stored keys or the stream port.
  always_comb begin
    w_wr_en  = nreset & (w_accept | w_busy);
    w_wr_idx = w_accept ? 4'd0 : r_round;
    w_wr_key = w_accept ? key_i : w_key_next;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_rk[w_wr_idx] <= w_wr_key;
      r_work         <= w_wr_key;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_rk_vld <= '0;
      r_done   <= 1'b0;
      r_round  <= 4'd0;
      r_rcon   <= 8'h00;
    end else begin
      r_done <= w_busy && (r_round == LastRound);
      if (w_accept) begin
        // Restart: only the cipher key itself is valid.
        r_rk_vld <= (NR+1)'(1);
        r_round  <= 4'd1;
        r_rcon   <= RCON_INIT;
      end else if (w_busy) begin
        r_rk_vld[r_round] <= 1'b1;
        r_round           <= r_round + 4'd1;
        r_rcon            <= w_rcon_next;
      end
    end
  end

  // ---------------- read port ----------------
  // A read that lands on the entry being written this edge returns the old contents but is
  // flagged as an error, since the data is about to change.
  always_comb begin
    w_rd_in_range = (rd_idx_i <= LastRound);
    w_rd_hit      = w_rd_in_range && r_rk_vld[rd_idx_i];
    w_rd_collide  = w_wr_en && (w_wr_idx == rd_idx_i);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_rd_key <= '0;
      r_rd_err <= 1'b0;
    end else if (rd_en_i) begin
      if (w_rd_collide) begin
        r_rd_key <= r_rk[rd_idx_i];
        r_rd_err <= 1'b1;
      end else if (!w_rd_hit) begin
        r_rd_key <= '0;
        r_rd_err <= 1'b1;
      end else begin
        r_rd_key <= r_rk[rd_idx_i];
        r_rd_err <= 1'b0;
      end
    end else begin
      r_rd_err <= 1'b0;
    end
  end

`ifdef AES_KEY_STREAM_EN
  logic          r_strm_valid;
  logic [3:0]    r_strm_idx;
  logic [KW-1:0] r_strm_key;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_strm_valid <= 1'b0;
      r_strm_idx   <= 4'd0;
      r_strm_key   <= '0;
    end else begin
      r_strm_valid <= w_wr_en;
      if (w_wr_en) begin
        r_strm_idx <= w_wr_idx;
        r_strm_key <= w_wr_key;
      end
    end
  end

  always_comb begin
    rk_strm_valid_o = r_strm_valid;
    rk_strm_idx_o   = r_strm_idx;
    rk_strm_key_o   = r_strm_key;
  end
`endif

endmodule
